imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default `PC_RESET, byte address of word 0.
REQ-002 SHALL have parameter DEPTH, default 1024, number of 32-bit words; power of two, >= 2.
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra cycles before response; range 0..15.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 SHALL have port i_IC_DataReq  input  1  fetch request from hart.
REQ-007 SHALL have port i_IM_Addr  input  32  fetch byte address.
REQ-008 SHALL have port o_IC_MemReady  output  1  one-cycle response strobe.
REQ-009 SHALL have port o_IM_Instr  output  32  fetched instruction; valid only while o_IC_MemReady=1.
REQ-010 SHALL have port i_ld_we  input  1  loader write enable.
REQ-011 SHALL have port i_ld_addr  input  $clog2(DEPTH)  loader word index.
REQ-012 SHALL have port i_ld_data  input  32  loader write data.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE with i_IC_DataReq=1 SHALL latch i_IM_Addr, load wait counter with WAIT_STATES, go to WAIT; if WAIT_STATES=0, go directly to RESP.
REQ-015 WAIT SHALL decrement counter each cycle; counter reaching 0 SHALL move to RESP on that edge.
REQ-016 RESP SHALL assert o_IC_MemReady for exactly one cycle, then return to IDLE.
REQ-017 Latency from request-sampling edge to o_IC_MemReady high SHALL be WAIT_STATES+1 cycles.
REQ-018 A new request SHALL be sampled only in IDLE; i_IC_DataReq high during RESP SHALL NOT start a transaction; earliest back-to-back acceptance is the cycle after RESP.
REQ-019 i_IM_Addr changes and i_IC_DataReq deassertion during WAIT SHALL be ignored; the latched transaction completes (no abort).
REQ-020 Word index SHALL be (latched_addr - BASE_ADDR) >> 2, 32-bit unsigned wrap-around subtraction; in range iff index < DEPTH and latched_addr[1:0] = 0.
REQ-021 o_IM_Instr SHALL be registered on the edge entering RESP from the array word at the index; out-of-range or misaligned SHALL give 32'h0000_0013 (NOP).
REQ-022 o_IM_Instr SHALL be 0 whenever o_IC_MemReady=0.
REQ-023 i_ld_we=1 SHALL write i_ld_data to word i_ld_addr on the rising edge, in any state.
REQ-024 Loader write to the word being read on the same edge as RESP entry SHALL NOT be visible (old data returned); a write on any earlier edge SHALL be visible.

Reset
REQ-025 i_rst=0 SHALL force IDLE, counter 0, o_IC_MemReady=0, o_IM_Instr=0, o_IC_Err=0 immediately, including mid-transaction; pending transaction SHALL be discarded.
REQ-026 Array contents SHALL NOT be cleared by reset.
REQ-027 First request SHALL be sampled on the first rising edge with i_rst=1.

Configuration
REQ-028 Macro IMEM_RESPONDER_ERR_EN SHALL, when defined, add port o_IC_Err  output  1, high together with o_IC_MemReady when the access is out of range or misaligned, 0 otherwise.
REQ-029 Without IMEM_RESPONDER_ERR_EN, o_IC_Err SHALL not exist; erroneous accesses SHALL still return 32'h0000_0013 per REQ-021.

Verification
REQ-030 WAIT_STATES=2, word 0 loaded 32'h0010_0093, req at BASE_ADDR -> MemReady high exactly 3 cycles after sampling edge, Instr=32'h0010_0093, one cycle only.
REQ-031 WAIT_STATES=0, req held high continuously at BASE_ADDR then BASE_ADDR+4 -> responses every 2 cycles, latency 1, correct words.
REQ-032 Req at BASE_ADDR+4*DEPTH, then BASE_ADDR+2 -> both return 32'h0000_0013; with IMEM_RESPONDER_ERR_EN, o_IC_Err=1 on both strobes.
REQ-033 Address changed and req dropped in WAIT -> response still issued with originally latched word.
REQ-034 i_rst=0 during WAIT -> outputs 0 asynchronously, no MemReady after release until a new request completes.
REQ-035 Loader write to index 5 on RESP-entry edge of a read of index 5 -> old data returned; re-read -> new data.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction memory responder: a word array with a loader write port that answers
// hart fetches after WAIT_STATES extra cycles. Define IMEM_RESPONDER_ERR_EN to add o_IC_Err.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = `PC_RESET,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_IC_DataReq,
    input  logic [31:0]              i_IM_Addr,
    output logic                     o_IC_MemReady,
    output logic [31:0]              o_IM_Instr,
    input  logic                     i_ld_we,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [31:0]              i_ld_data
`ifdef IMEM_RESPONDER_ERR_EN
    ,
    output logic                     o_IC_Err
`endif
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [31:0]   addr_q, addr_nxt;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   fetch_addr;
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          enter_resp;
    logic [31:0]   instr_q;

    // With zero wait states RESP is entered on the sampling edge itself, before the
    // address has been latched, so the lookup must use the live address in IDLE.
    always_comb begin
        fetch_addr = (state == IDLE) ? i_IM_Addr : addr_q;
        offset     = fetch_addr - BASE_ADDR;
        word_idx   = offset[AW+1:2];
        in_range   = (offset[31:2] < 30'(DEPTH)) && (fetch_addr[1:0] == 2'b00);
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        addr_nxt   = addr_q;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (i_IC_DataReq) begin
                    addr_nxt = i_IM_Addr;
                    if (WAIT_STATES == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) begin
                    cnt_nxt    = 4'd0;
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 32'd0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
        end
    end

    // Array has no reset so loaded code survives a hart reset.
    always_ff @(posedge i_clk) begin
        if (i_ld_we) begin
            mem[i_ld_addr] <= i_ld_data;
        end
    end

`ifdef IMEM_RESPONDER_ERR_EN
    logic err_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            instr_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            instr_q <= in_range ? mem[word_idx] : NOP;
            err_q   <= ~in_range;
        end else begin
            instr_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    assign o_IC_Err = err_q;
`else
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            instr_q <= 32'd0;
        end else if (enter_resp) begin
            instr_q <= in_range ? mem[word_idx] : NOP;
        end else begin
            instr_q <= 32'd0;
        end
    end
`endif

    assign o_IC_MemReady = (state == RESP);
    assign o_IM_Instr    = instr_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one instance with two wait states, one with none,
// sharing clock, reset and loader port.
module tb_imem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] W0    = 32'h0010_0093;
    localparam logic [31:0] W1    = 32'h0020_0113;
    localparam logic [31:0] W2    = 32'h0030_0193;
    localparam logic [31:0] W3    = 32'h0040_0213;
    localparam logic [31:0] W5    = 32'h0050_0293;
    localparam logic [31:0] W15   = 32'h00F0_0F93;
    localparam logic [31:0] NEW1  = 32'h0060_0313;
    localparam logic [31:0] NEW2  = 32'h0070_0393;

    logic        clk;
    logic        rst;
    logic        req2, req0;
    logic [31:0] addr2, addr0;
    logic        rdy2, rdy0;
    logic [31:0] instr2, instr0;
    logic        ld_we;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
`ifdef IMEM_RESPONDER_ERR_EN
    logic        err2, err0;
`endif

    int checks = 0;
    int errors = 0;

    imem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_IC_DataReq(req2), .i_IM_Addr(addr2),
        .o_IC_MemReady(rdy2), .o_IM_Instr(instr2),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
`ifdef IMEM_RESPONDER_ERR_EN
        , .o_IC_Err(err2)
`endif
    );

    imem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_IC_DataReq(req0), .i_IM_Addr(addr0),
        .o_IC_MemReady(rdy0), .o_IM_Instr(instr0),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
`ifdef IMEM_RESPONDER_ERR_EN
        , .o_IC_Err(err0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_word(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks += 4;
        if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy2: got %b expected 0", rdy2); end
        if (instr2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr2: got %h expected 0", instr2); end
        if (rdy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy0: got %b expected 0", rdy0); end
        if (instr0 !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr0: got %h expected 0", instr0); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Request sampled on the edge after the drive; strobe is visible in the third cycle.
    task automatic test_latency;
        logic [31:0] exp_i;
        @(negedge clk);
        req2  = 1'b1;
        addr2 = BASE;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req2  = 1'b0;
            exp_i = (k == 3) ? W0 : 32'd0;
            checks += 2;
            if (rdy2 !== (k == 3)) begin errors++; $display("[TB] FAIL latency_rdy[%0d]: got %b expected %b", k, rdy2, (k == 3)); end
            if (instr2 !== exp_i) begin errors++; $display("[TB] FAIL latency_instr[%0d]: got %h expected %h", k, instr2, exp_i); end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req0  = 1'b1;
        addr0 = BASE;
        @(negedge clk);
        checks += 2;
        if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rdy_first: got %b expected 1", rdy0); end
        if (instr0 !== W0) begin errors++; $display("[TB] FAIL b2b_instr_first: got %h expected %h", instr0, W0); end
        addr0 = BASE + 32'd4;
        @(negedge clk);
        checks += 2;
        if (rdy0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rdy_gap: got %b expected 0", rdy0); end
        if (instr0 !== 32'd0) begin errors++; $display("[TB] FAIL b2b_instr_gap: got %h expected 0", instr0); end
        @(negedge clk);
        checks += 2;
        if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rdy_second: got %b expected 1", rdy0); end
        if (instr0 !== W1) begin errors++; $display("[TB] FAIL b2b_instr_second: got %h expected %h", instr0, W1); end
        req0 = 1'b0;
        @(negedge clk);
        checks += 1;
        if (rdy0 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_rdy_end: got %b expected 0", rdy0); end
    endtask

    task automatic test_errors;
        logic [31:0] bad [2];
        logic [31:0] a0 [2];
        logic [31:0] e0 [2];
        logic        x0 [2];
        bad[0] = BASE + 32'd64;
        bad[1] = BASE + 32'd2;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            req2  = 1'b1;
            addr2 = bad[n];
            @(negedge clk);
            req2 = 1'b0;
            repeat (2) @(negedge clk);
            checks += 2;
            if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL err_rdy[%0d]: got %b expected 1", n, rdy2); end
            if (instr2 !== NOP) begin errors++; $display("[TB] FAIL err_instr[%0d]: got %h expected %h", n, instr2, NOP); end
`ifdef IMEM_RESPONDER_ERR_EN
            checks += 1;
            if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL err_flag[%0d]: got %b expected 1", n, err2); end
`endif
        end
        @(negedge clk);
        // Last valid word, then an address below the base that wraps far out of range.
        a0[0] = BASE + 32'd60; e0[0] = W15; x0[0] = 1'b0;
        a0[1] = BASE - 32'd4;  e0[1] = NOP; x0[1] = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            req0  = 1'b1;
            addr0 = a0[n];
            @(negedge clk);
            req0 = 1'b0;
            checks += 2;
            if (rdy0 !== 1'b1) begin errors++; $display("[TB] FAIL edge_rdy[%0d]: got %b expected 1", n, rdy0); end
            if (instr0 !== e0[n]) begin errors++; $display("[TB] FAIL edge_instr[%0d]: got %h expected %h", n, instr0, e0[n]); end
`ifdef IMEM_RESPONDER_ERR_EN
            checks += 1;
            if (err0 !== x0[n]) begin errors++; $display("[TB] FAIL edge_err[%0d]: got %b expected %b", n, err0, x0[n]); end
`else
            if (x0[n] === 1'bx) $display("[TB] unreachable");
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_wait_ignore;
        @(negedge clk);
        req2  = 1'b1;
        addr2 = BASE + 32'd8;
        @(negedge clk);
        req2  = 1'b0;
        addr2 = BASE + 32'd12;
        @(negedge clk);
        addr2 = BASE + 32'd64;
        @(negedge clk);
        checks += 2;
        if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL ignore_rdy: got %b expected 1", rdy2); end
        if (instr2 !== W2) begin errors++; $display("[TB] FAIL ignore_instr: got %h expected %h", instr2, W2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req2  = 1'b1;
        addr2 = BASE + 32'd8;
        @(negedge clk);
        req2 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 2;
        if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rdy: got %b expected 0", rdy2); end
        if (instr2 !== 32'd0) begin errors++; $display("[TB] FAIL midrst_instr: got %h expected 0", instr2); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks += 1;
            if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_discard[%0d]: got %b expected 0", k, rdy2); end
        end
        @(negedge clk);
        req2  = 1'b1;
        addr2 = BASE + 32'd4;
        @(negedge clk);
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL resprst_pre_rdy: got %b expected 1", rdy2); end
        if (instr2 !== W1) begin errors++; $display("[TB] FAIL resprst_pre_instr: got %h expected %h", instr2, W1); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL resprst_rdy: got %b expected 0", rdy2); end
        if (instr2 !== 32'd0) begin errors++; $display("[TB] FAIL resprst_instr: got %h expected 0", instr2); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req2  = 1'b1;
        addr2 = BASE + 32'd12;
        @(negedge clk);
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        checks += 2;
        if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL postrst_rdy: got %b expected 1", rdy2); end
        if (instr2 !== W3) begin errors++; $display("[TB] FAIL postrst_instr: got %h expected %h", instr2, W3); end
        @(negedge clk);
    endtask

    task automatic test_loader_collision;
        // Write lands on the very edge that enters RESP: the old word must be returned.
        @(negedge clk);
        req2  = 1'b1;
        addr2 = BASE + 32'd20;
        @(negedge clk);
        req2 = 1'b0;
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = 4'd5;
        ld_data = NEW1;
        @(negedge clk);
        ld_we = 1'b0;
        checks += 2;
        if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL collide_rdy: got %b expected 1", rdy2); end
        if (instr2 !== W5) begin errors++; $display("[TB] FAIL collide_instr: got %h expected %h", instr2, W5); end
        @(negedge clk);
        req2 = 1'b1;
        @(negedge clk);
        req2 = 1'b0;
        repeat (2) @(negedge clk);
        checks += 1;
        if (instr2 !== NEW1) begin errors++; $display("[TB] FAIL reread_instr: got %h expected %h", instr2, NEW1); end
        @(negedge clk);
        req2 = 1'b1;
        @(negedge clk);
        req2    = 1'b0;
        ld_we   = 1'b1;
        ld_data = NEW2;
        @(negedge clk);
        ld_we = 1'b0;
        @(negedge clk);
        checks += 1;
        if (instr2 !== NEW2) begin errors++; $display("[TB] FAIL early_write_instr: got %h expected %h", instr2, NEW2); end
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        req2    = 1'b0;
        req0    = 1'b0;
        addr2   = 32'd0;
        addr0   = 32'd0;
        ld_we   = 1'b0;
        ld_addr = 4'd0;
        ld_data = 32'd0;
        test_reset();
        load_word(4'd0, W0);
        load_word(4'd1, W1);
        load_word(4'd2, W2);
        load_word(4'd3, W3);
        load_word(4'd5, W5);
        load_word(4'd15, W15);
        test_latency();
        test_back_to_back();
        test_errors();
        test_wait_ignore();
        test_reset_mid();
        test_loader_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
